rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 3, meaning register address width (8 registers).
REQ-002 The block SHALL have parameter DW, default 8, meaning register data width.
REQ-003 Port Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req0  input  1  requester 0 write request.
REQ-006 Port addr0  input  AW  requester 0 target register.
REQ-007 Port data0  input  DW  requester 0 write data.
REQ-008 Port gnt0  output  1  requester 0 grant, one-cycle pulse.
REQ-009 Ports req1, addr1, data1, gnt1 SHALL mirror REQ-005..008 for requester 1.
REQ-010 Port clr_req  input  1  request to zero registers 1..7.
REQ-011 Port clr_busy  output  1  clear sequence in progress.
REQ-012 Port zero_wr  output  1  one-cycle pulse: granted write targeted register 0 and was suppressed.
REQ-013 Ports WEN (1), RW (AW), busW (DW) SHALL be outputs driving the register file write port (WEN active-high).

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 FSM states SHALL be IDLE and CLEAR only.
REQ-016 In IDLE, at each rising edge with at least one eligible request, exactly one requester SHALL be selected; gntN, WEN, RW=addrN, busW=dataN SHALL be high/valid during the following cycle only.
REQ-017 A requester SHALL be ineligible in any cycle where its own gnt is high; requesters hold req/addr/data stable until they observe gnt.
REQ-018 Arbitration SHALL be round-robin: a priority pointer, 0 after reset, moves to the non-granted requester after every grant; with a single eligible request, that request wins regardless of pointer.
REQ-019 Alternating requesters SHALL sustain one write per cycle; a single requester SHALL achieve one write per two cycles.
REQ-020 A granted write with addrN=0 SHALL assert gntN and zero_wr but hold WEN=0.
REQ-021 When no write issues, WEN=0, RW=0, busW=0, gnt0=gnt1=0.
REQ-022 clr_req sampled high in IDLE SHALL take priority over req0/req1 at that edge and enter CLEAR.
REQ-023 In CLEAR, seven consecutive cycles SHALL drive WEN=1, busW=0, RW=1,2,...,7; clr_busy=1 exactly during those seven cycles; then return to IDLE.
REQ-024 In CLEAR, no gnt SHALL assert, clr_req SHALL be ignored, and pending reqs SHALL wait and be arbitrated normally on return to IDLE; the pointer SHALL be unchanged by CLEAR.

Reset
REQ-025 Rst_n low SHALL immediately force IDLE, pointer=0, gnt0=gnt1=0, WEN=0, RW=0, busW=0, clr_busy=0, zero_wr=0.
REQ-026 Reset asserted mid-CLEAR SHALL abort the sequence with no further writes; reset release SHALL resume in IDLE.

Configuration
REQ-027 Macro RF_ARB_CLEAR_EN defined SHALL compile in the CLEAR state and REQ-022..024 behaviour.
REQ-028 Without RF_ARB_CLEAR_EN, clr_req SHALL be ignored, clr_busy SHALL be constant 0, and the FSM SHALL remain in IDLE.

Verification
REQ-029 Reset, then req0=1 addr0=3 data0=8'hA5 -> next cycle gnt0=1, WEN=1, RW=3, busW=A5; register 3 reads A5 afterwards.
REQ-030 req0 and req1 held high continuously (addr0=1, addr1=2) -> grants alternate gnt0,gnt1,gnt0,... every cycle starting with gnt0.
REQ-031 req1=1 addr1=0 data1=8'hFF -> gnt1=1, zero_wr=1, WEN=0; register 0 still reads 0.
REQ-032 Registers 1..7 loaded with 8'h55, clr_req pulse with req0 pending (RF_ARB_CLEAR_EN) -> seven cycles RW=1..7 busW=0 clr_busy=1, then gnt0; all registers 1..7 read 0 before req0's write.
REQ-033 Rst_n pulsed low during third CLEAR cycle -> all outputs 0 immediately; registers 3..7 keep 8'h55.
REQ-034 Build without RF_ARB_CLEAR_EN, clr_req=1 for 10 cycles -> clr_busy=0, WEN=0, no register changes.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - requester, clear and register-file write-port bundle for rf_write_arbiter
interface rf_write_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          gnt0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic          gnt1;
    logic          clr_req;
    logic          clr_busy;
    logic          zero_wr;
    logic          WEN;
    logic [AW-1:0] RW;
    logic [DW-1:0] busW;

    modport master (
        output req0, addr0, data0, req1, addr1, data1, clr_req,
        input  gnt0, gnt1, clr_busy, zero_wr, WEN, RW, busW
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, clr_req,
        output gnt0, gnt1, clr_busy, zero_wr, WEN, RW, busW
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-requester round-robin register-file write arbiter with optional clear sweep
// Optional clear sequence of registers 1..7 is compiled in with `define RF_ARB_CLEAR_EN.
module rf_write_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input logic               Clk,
    input logic               Rst_n,
    rf_write_arbiter_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          wen_q, wen_d;
    logic          zero_q, zero_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] busw_q, busw_d;

    logic          elig0, elig1, any_elig, sel1;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

`ifdef RF_ARB_CLEAR_EN
    logic [2:0]    clr_cnt_q, clr_cnt_d;
`else
    logic          unused_clr_req;
    assign unused_clr_req = bus.clr_req;
`endif

    // A requester whose grant is showing this cycle still holds its old request.
    assign elig0    = bus.req0 & ~gnt0_q;
    assign elig1    = bus.req1 & ~gnt1_q;
    assign any_elig = elig0 | elig1;
    assign sel1     = elig1 & (~elig0 | ptr_q);
    assign sel_addr = sel1 ? bus.addr1 : bus.addr0;
    assign sel_data = sel1 ? bus.data1 : bus.data0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            wen_q     <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= '0;
            busw_q    <= '0;
`ifdef RF_ARB_CLEAR_EN
            clr_cnt_q <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            wen_q     <= wen_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            busw_q    <= busw_d;
`ifdef RF_ARB_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        wen_d     = 1'b0;
        zero_d    = 1'b0;
        busy_d    = 1'b0;
        rw_d      = '0;
        busw_d    = '0;
`ifdef RF_ARB_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef RF_ARB_CLEAR_EN
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = 3'd1;
                    wen_d     = 1'b1;
                    rw_d      = AW'(1);
                    busy_d    = 1'b1;
                end else
`endif
                if (any_elig) begin
                    ptr_d  = ~sel1;
                    gnt0_d = ~sel1;
                    gnt1_d = sel1;
                    // Register 0 is hardwired: grant the requester but keep the write port quiet.
                    if (sel_addr == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        wen_d  = 1'b1;
                        rw_d   = sel_addr;
                        busw_d = sel_data;
                    end
                end
            end
            CLEAR: begin
`ifdef RF_ARB_CLEAR_EN
                // clr_cnt_q is the register written in the cycle now ending.
                if (clr_cnt_q == 3'd7) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 3'd1;
                    wen_d     = 1'b1;
                    rw_d      = AW'(clr_cnt_q + 3'd1);
                    busy_d    = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.WEN      = wen_q;
    assign bus.RW       = rw_q;
    assign bus.busW     = busw_q;
    assign bus.zero_wr  = zero_q;
    assign bus.clr_busy = busy_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - randomized self-checking bench for rf_write_arbiter against a behavioural model
module tb_rf_write_arbiter;
    localparam int AW = 3;
    localparam int DW = 8;
`ifdef RF_ARB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    rf_write_arbiter_if #(.AW(AW), .DW(DW)) ifc ();
    rf_write_arbiter #(.AW(AW), .DW(DW)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(ifc.slave));

    logic [DW-1:0] regs [8] = '{default: '0};
    always @(posedge Clk) if (ifc.WEN) regs[ifc.RW] <= ifc.busW;

    wire [AW+DW+4:0] obs = {ifc.gnt0, ifc.gnt1, ifc.WEN, ifc.RW, ifc.busW, ifc.zero_wr, ifc.clr_busy};

    int n_checks = 0;
    int n_errors = 0;

    // Model: expected outputs for the cycle after each edge, register contents, pointer, clear progress.
    bit            e_g0, e_g1, e_wen, e_zero, e_busy;
    logic [AW-1:0] e_rw;
    logic [DW-1:0] e_bus;
    logic [DW-1:0] m_regs [8] = '{default: '0};
    int            m_ptr;
    bit            m_in_clear;
    int            m_next_rw;

    function automatic logic [AW+DW+4:0] exp_vec();
        return {e_g0, e_g1, e_wen, e_rw, e_bus, e_zero, e_busy};
    endfunction

    function automatic void model_reset();
        e_g0 = 0; e_g1 = 0; e_wen = 0; e_zero = 0; e_busy = 0; e_rw = '0; e_bus = '0;
        m_ptr = 0; m_in_clear = 0; m_next_rw = 0;
    endfunction

    function automatic void model_edge();
        bit el0, el1;
        int w;
        logic [AW-1:0] a;
        el0 = ifc.req0 && !e_g0;
        el1 = ifc.req1 && !e_g1;
        if (e_wen) m_regs[e_rw] = e_bus;
        e_g0 = 0; e_g1 = 0; e_wen = 0; e_zero = 0; e_busy = 0; e_rw = '0; e_bus = '0;
        if (m_in_clear) begin
            if (m_next_rw <= 7) begin
                e_wen = 1; e_busy = 1; e_rw = AW'(m_next_rw);
                m_next_rw++;
            end else begin
                m_in_clear = 0;
            end
        end else if (CLEAR_EN && ifc.clr_req) begin
            m_in_clear = 1; e_wen = 1; e_busy = 1; e_rw = AW'(1); m_next_rw = 2;
        end else if (el0 || el1) begin
            w = (el0 && el1) ? m_ptr : (el0 ? 0 : 1);
            m_ptr = 1 - w;
            a = (w == 1) ? ifc.addr1 : ifc.addr0;
            if (w == 1) e_g1 = 1; else e_g0 = 1;
            if (a == '0) begin
                e_zero = 1;
            end else begin
                e_wen = 1; e_rw = a;
                e_bus = (w == 1) ? ifc.data1 : ifc.data0;
            end
        end
    endfunction

    task automatic do_reset();
        ifc.req0 = 0; ifc.req1 = 0; ifc.clr_req = 0;
        ifc.addr0 = '0; ifc.addr1 = '0; ifc.data0 = '0; ifc.data1 = '0;
        Rst_n = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1;
    endtask

    task automatic test_reset();
        ifc.req0 = 1; ifc.addr0 = 3'd2; ifc.data0 = 8'h11;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL reset_outputs got=%h want=0", obs);
        end
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        ifc.req0 = 1; ifc.addr0 = 3'd3; ifc.data0 = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            model_edge(); @(posedge Clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL single_write cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (i == 0) begin
                n_checks++;
                if (obs !== {1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0}) begin
                    n_errors++; $display("FAIL single_write_first got=%h want=%h", obs, {1'b1, 1'b0, 1'b1, 3'd3, 8'hA5, 2'b00});
                end
            end
            if (e_g0) ifc.req0 = 0;
        end
        n_checks++;
        if (regs[3] !== 8'hA5) begin
            n_errors++; $display("FAIL single_write_reg3 got=%h want=a5", regs[3]);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        ifc.req0 = 1; ifc.addr0 = 3'd1; ifc.data0 = DW'($urandom);
        ifc.req1 = 1; ifc.addr1 = 3'd2; ifc.data1 = DW'($urandom);
        for (int i = 0; i < 10; i++) begin
            model_edge(); @(posedge Clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL alternate cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
            n_checks++;
            if ({ifc.gnt0, ifc.gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_errors++; $display("FAIL alternate_order cyc%0d got=%b want=%b", i, {ifc.gnt0, ifc.gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (e_g0) ifc.data0 = DW'($urandom);
            if (e_g1) ifc.data1 = DW'($urandom);
        end
        ifc.req0 = 0; ifc.req1 = 0;
    endtask

    task automatic test_single_rate();
        int grants = 0;
        do_reset();
        ifc.req1 = 1; ifc.addr1 = AW'($urandom_range(1, 7)); ifc.data1 = DW'($urandom);
        for (int i = 0; i < 12; i++) begin
            model_edge(); @(posedge Clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL single_rate cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (ifc.gnt1 === 1'b1) grants++;
            if (e_g1) begin
                ifc.addr1 = AW'($urandom_range(1, 7)); ifc.data1 = DW'($urandom);
            end
        end
        ifc.req1 = 0;
        n_checks++;
        if (grants != 6) begin
            n_errors++; $display("FAIL single_rate_count got=%0d want=6", grants);
        end
    endtask

    task automatic test_zero_write();
        do_reset();
        ifc.req1 = 1; ifc.addr1 = 3'd0; ifc.data1 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            model_edge(); @(posedge Clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL zero_write cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (i == 0) begin
                n_checks++;
                if ({ifc.gnt1, ifc.zero_wr, ifc.WEN} !== 3'b110) begin
                    n_errors++; $display("FAIL zero_write_flags got=%b want=110", {ifc.gnt1, ifc.zero_wr, ifc.WEN});
                end
            end
            if (e_g1) ifc.req1 = 0;
        end
        n_checks++;
        if (regs[0] !== 8'h00) begin
            n_errors++; $display("FAIL zero_write_reg0 got=%h want=00", regs[0]);
        end
    endtask

    task automatic load_55();
        for (int a = 1; a < 8; a++) begin
            ifc.req0 = 1; ifc.addr0 = AW'(a); ifc.data0 = 8'h55;
            for (int i = 0; i < 2; i++) begin
                model_edge(); @(posedge Clk); #1;
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_errors++; $display("FAIL load55 reg%0d cyc%0d got=%h want=%h", a, i, obs, exp_vec());
                end
                if (e_g0) ifc.req0 = 0;
            end
        end
        model_edge(); @(posedge Clk); #1;
    endtask

    task automatic test_async_reset();
        do_reset();
        ifc.req0 = 1; ifc.addr0 = 3'd5; ifc.data0 = 8'h3C;
        model_edge(); @(posedge Clk); #1;
        n_checks++;
        if (obs !== exp_vec()) begin
            n_errors++; $display("FAIL async_reset_pre got=%h want=%h", obs, exp_vec());
        end
        #2 Rst_n = 0;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL async_reset_immediate got=%h want=0", obs);
        end
        ifc.req0 = 0;
        model_reset();
        @(posedge Clk); #1;
        n_checks++;
        if (regs[5] !== m_regs[5]) begin
            n_errors++; $display("FAIL async_reset_reg5 got=%h want=%h", regs[5], m_regs[5]);
        end
        Rst_n = 1;
    endtask

`ifdef RF_ARB_CLEAR_EN
    task automatic test_clear();
        bit got = 0;
        int busy_cycles = 0;
        do_reset();
        load_55();
        ifc.clr_req = 1; ifc.req0 = 1; ifc.addr0 = 3'd3; ifc.data0 = 8'h77;
        for (int i = 0; i < 20 && !got; i++) begin
            model_edge(); @(posedge Clk); #1;
            ifc.clr_req = 0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL clear cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (ifc.clr_busy === 1'b1) busy_cycles++;
            if (i < 7) begin
                n_checks++;
                if ({ifc.WEN, ifc.RW, ifc.busW, ifc.clr_busy, ifc.gnt0} !== {1'b1, 3'(i + 1), 8'h00, 1'b1, 1'b0}) begin
                    n_errors++; $display("FAIL clear_sweep cyc%0d got=%h want=RW%0d", i, obs, i + 1);
                end
            end
            if (ifc.gnt0 === 1'b1) begin
                got = 1;
                ifc.req0 = 0;
                for (int a = 1; a < 8; a++) begin
                    n_checks++;
                    if (regs[a] !== 8'h00) begin
                        n_errors++; $display("FAIL clear_reg%0d got=%h want=00", a, regs[a]);
                    end
                end
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++; $display("FAIL clear_gnt0_timeout got=none want=gnt0 within 20 cycles");
        end
        n_checks++;
        if (busy_cycles != 7) begin
            n_errors++; $display("FAIL clear_busy_len got=%0d want=7", busy_cycles);
        end
        ifc.req0 = 0;
        model_edge(); @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        load_55();
        ifc.clr_req = 1;
        for (int i = 0; i < 3; i++) begin
            model_edge(); @(posedge Clk); #1;
            ifc.clr_req = 0;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL midclr cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        #2 Rst_n = 0;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++; $display("FAIL midclr_immediate got=%h want=0", obs);
        end
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1;
        for (int a = 1; a < 8; a++) begin
            n_checks++;
            if (regs[a] !== ((a < 3) ? 8'h00 : 8'h55)) begin
                n_errors++; $display("FAIL midclr_reg%0d got=%h want=%h", a, regs[a], (a < 3) ? 8'h00 : 8'h55);
            end
        end
        ifc.req0 = 1; ifc.addr0 = 3'd4; ifc.data0 = 8'h9E;
        for (int i = 0; i < 2; i++) begin
            model_edge(); @(posedge Clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL midclr_resume cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (e_g0) ifc.req0 = 0;
        end
    endtask
`else
    task automatic test_clear_ignored();
        do_reset();
        ifc.clr_req = 1;
        for (int i = 0; i < 10; i++) begin
            model_edge(); @(posedge Clk); #1;
            n_checks++;
            if ({ifc.clr_busy, ifc.WEN} !== 2'b00 || obs !== exp_vec()) begin
                n_errors++; $display("FAIL clear_ignored cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        ifc.clr_req = 0;
        for (int a = 0; a < 8; a++) begin
            n_checks++;
            if (regs[a] !== m_regs[a]) begin
                n_errors++; $display("FAIL clear_ignored_reg%0d got=%h want=%h", a, regs[a], m_regs[a]);
            end
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            model_edge(); @(posedge Clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_errors++; $display("FAIL random cyc%0d got=%h want=%h", i, obs, exp_vec());
            end
            if (!ifc.req0 || e_g0) begin
                ifc.req0 = ($urandom_range(0, 2) != 0);
                ifc.addr0 = AW'($urandom_range(0, 7)); ifc.data0 = DW'($urandom);
            end
            if (!ifc.req1 || e_g1) begin
                ifc.req1 = ($urandom_range(0, 2) != 0);
                ifc.addr1 = AW'($urandom_range(0, 7)); ifc.data1 = DW'($urandom);
            end
            ifc.clr_req = ($urandom_range(0, 29) == 0);
        end
        ifc.req0 = 0; ifc.req1 = 0; ifc.clr_req = 0;
        for (int i = 0; i < 10; i++) begin
            model_edge(); @(posedge Clk); #1;
        end
        for (int a = 0; a < 8; a++) begin
            n_checks++;
            if (regs[a] !== m_regs[a]) begin
                n_errors++; $display("FAIL random_reg%0d got=%h want=%h", a, regs[a], m_regs[a]);
            end
        end
    endtask

    initial begin
        ifc.req0 = 0; ifc.req1 = 0; ifc.clr_req = 0;
        ifc.addr0 = '0; ifc.addr1 = '0; ifc.data0 = '0; ifc.data1 = '0;
        model_reset();
        test_reset();
        test_single_write();
        test_alternate();
        test_single_rate();
        test_zero_write();
        test_async_reset();
`ifdef RF_ARB_CLEAR_EN
        test_clear();
        test_reset_mid_clear();
`else
        test_clear_ignored();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
